// File: rtl/testbus_led_monitor.sv
// Test bus change monitor: event pulse, saturating count, stretched LED.
// Heartbeat blink in idle built only with TESTBUS_MON_HEARTBEAT_EN.
module testbus_led_monitor #(
  parameter int STRETCH_CYCLES = 20000000,
  parameter int HEARTBEAT_DIV  = 100000000,
  parameter int CNT_W          = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [7:0]       iv_TEST,
  input  logic [7:0]       iv_MASK,
  input  logic             i_CLR,
  output logic             o_EVENT,
  output logic [7:0]       ov_LAST_CHANGE,
  output logic [CNT_W-1:0] ov_EVENT_CNT,
  output logic             o_LED
);

  localparam int MAXP =
    (STRETCH_CYCLES > HEARTBEAT_DIV) ? STRETCH_CYCLES
                                     : HEARTBEAT_DIV;
  localparam int TW = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [TW-1:0] STR_LD = TW'(STRETCH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(STRETCH_CYCLES / 4 - 1);
  localparam logic [TW-1:0] T_ZERO = '0;
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_HEART,
    S_STRETCH,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [7:0]  r_prev;
  logic        r_primed;
  logic [7:0]  diff;
  logic        ev;
  logic        hb_led;
  logic        led_nxt;

  assign diff = (iv_TEST ^ r_prev) & iv_MASK;
  assign ev   = r_primed && (diff != 8'h00);

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_prev         <= 8'h00;
      r_primed       <= 1'b0;
      o_EVENT        <= 1'b0;
      ov_LAST_CHANGE <= 8'h00;
      ov_EVENT_CNT   <= '0;
    end else begin
      r_prev   <= iv_TEST;
      r_primed <= 1'b1;
      o_EVENT  <= ev;
      if (ev) begin
        ov_LAST_CHANGE <= diff;
      end
      // clear takes priority over a coincident event
      if (i_CLR) begin
        ov_EVENT_CNT <= '0;
      end else if (ev && ov_EVENT_CNT != CNT_MAX) begin
        ov_EVENT_CNT <= ov_EVENT_CNT + CNT_ONE;
      end
    end
  end

`ifdef TESTBUS_MON_HEARTBEAT_EN
  localparam logic [TW-1:0] HB_TC = TW'(HEARTBEAT_DIV - 1);

  logic [TW-1:0] hb_cnt;
  logic [TW-1:0] hb_cnt_nxt;
  logic          hb_tgl;
  logic          hb_tgl_nxt;

  always_comb begin
    hb_cnt_nxt = T_ZERO;
    hb_tgl_nxt = 1'b0;
    // counting only while staying in S_HEART; entry restarts at 0
    if (state == S_HEART && state_nxt == S_HEART) begin
      if (hb_cnt == HB_TC) begin
        hb_cnt_nxt = T_ZERO;
        hb_tgl_nxt = ~hb_tgl;
      end else begin
        hb_cnt_nxt = hb_cnt + T_ONE;
        hb_tgl_nxt = hb_tgl;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      hb_cnt <= T_ZERO;
      hb_tgl <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt_nxt;
      hb_tgl <= hb_tgl_nxt;
    end
  end

  assign hb_led = hb_tgl;
`else
  assign hb_led = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    led_nxt   = 1'b0;
    unique case (state)
      S_HEART: begin
        led_nxt = hb_led;
        if (ev) begin
          state_nxt = S_STRETCH;
          timer_nxt = STR_LD;
        end
      end
      S_STRETCH: begin
        led_nxt = 1'b1;
        if (ev) begin
          timer_nxt = STR_LD;
        end else if (timer == T_ZERO) begin
          state_nxt = S_GAP;
          timer_nxt = GAP_LD;
        end else begin
          timer_nxt = timer - T_ONE;
        end
      end
      S_GAP: begin
        led_nxt = 1'b0;
        if (ev) begin
          state_nxt = S_STRETCH;
          timer_nxt = STR_LD;
        end else if (timer == T_ZERO) begin
          state_nxt = S_HEART;
          timer_nxt = T_ZERO;
        end else begin
          timer_nxt = timer - T_ONE;
        end
      end
      default: begin
        state_nxt = S_HEART;
        timer_nxt = T_ZERO;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state <= S_HEART;
      timer <= T_ZERO;
      o_LED <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      o_LED <= led_nxt;
    end
  end

endmodule

// File: tb/tb_testbus_led_monitor.sv
// Randomized bench for testbus_led_monitor against a timeline model
// of the LED keyed on the edge index of the most recent event.
module tb_testbus_led_monitor;

  localparam int S  = 8;
  localparam int HB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    test;
  logic [7:0]    mask;
  logic          clr;
  logic          ev_o;
  logic [7:0]    last_o;
  logic [CW-1:0] cnt_o;
  logic          led_o;

  testbus_led_monitor #(
    .STRETCH_CYCLES(S),
    .HEARTBEAT_DIV (HB),
    .CNT_W         (CW)
  ) dut (
    .i_CLK         (clk),
    .i_RESET       (rst),
    .iv_TEST       (test),
    .iv_MASK       (mask),
    .i_CLR         (clr),
    .o_EVENT       (ev_o),
    .ov_LAST_CHANGE(last_o),
    .ov_EVENT_CNT  (cnt_o),
    .o_LED         (led_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int       n;
  bit       primed;
  bit       have_ev;
  int       last_ev;
  bit       m_ev;
  bit       m_led;
  int       m_cnt;
  logic [7:0] m_prev;
  logic [7:0] m_last;
  logic [7:0] cur;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h exp=%0h",
                  tag, n, got, exp);
  endtask

  function automatic bit hb(input int y);
`ifdef TESTBUS_MON_HEARTBEAT_EN
    return ((y / HB) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // LED level implied by the state held after edge x
  function automatic bit led_at(input int x);
    int d;
    if (!have_ev) return hb(x);
    d = x - last_ev;
    if (d < S) return 1'b1;
    if (d < S + S / 4) return 1'b0;
    return hb(d - (S + S / 4));
  endfunction

  task automatic model_reset();
    n       = 0;
    primed  = 1'b0;
    have_ev = 1'b0;
    last_ev = 0;
    m_ev    = 1'b0;
    m_cnt   = 0;
    m_prev  = 8'h00;
    m_last  = 8'h00;
  endtask

  task automatic step(input logic [7:0] tv,
                      input logic [7:0] mv,
                      input logic cv);
    logic [7:0] d;
    test = tv;
    mask = mv;
    clr  = cv;
    @(posedge clk);
    m_led = led_at(n);
    n++;
    d    = (tv ^ m_prev) & mv;
    m_ev = primed && (d != 8'h00);
    if (m_ev) begin
      m_last  = d;
      have_ev = 1'b1;
      last_ev = n;
    end
    if (cv) m_cnt = 0;
    else if (m_ev && m_cnt < (1 << CW) - 1) m_cnt++;
    m_prev = tv;
    primed = 1'b1;
    cur    = tv;
    #1;
    chk("event", 32'(ev_o), 32'(m_ev));
    chk("last_change", 32'(last_o), 32'(m_last));
    chk("count", 32'(cnt_o), 32'(m_cnt));
    chk("led", 32'(led_o), 32'(m_led));
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) step(cur, mask, 1'b0);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_led", 32'(led_o), 32'd0);
    chk("rst_event", 32'(ev_o), 32'd0);
    chk("rst_count", 32'(cnt_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    test = 8'hA5;
    mask = 8'hFF;
    clr  = 1'b0;
    cur  = 8'hA5;
    model_reset();
    #11;
    chk("init_led", 32'(led_o), 32'd0);
    chk("init_event", 32'(ev_o), 32'd0);
    chk("init_count", 32'(cnt_o), 32'd0);
    chk("init_last", 32'(last_o), 32'd0);
    #1;
    rst = 1'b0;

    // priming edge and idle heartbeat
    for (int i = 0; i < 12; i++) step(8'hA5, 8'hFF, 1'b0);

    // single masked change, full stretch/gap/heartbeat
    for (int i = 0; i < 13; i++) step(8'h00, 8'h00, 1'b0);
    step(8'h81, 8'h01, 1'b0);
    hold(16);

    // all bits toggling with mask off
    for (int i = 0; i < 10; i++) step(~cur, 8'h00, 1'b0);

    // saturation with back-to-back events
    for (int i = 0; i < 20; i++) step(cur ^ 8'h01, 8'hFF, 1'b0);
    hold(3);
    step(cur, 8'hFF, 1'b1);
    hold(14);

    // retrigger mid-stretch, then event during gap
    step(cur ^ 8'h10, 8'hFF, 1'b0);
    hold(5);
    step(cur ^ 8'h10, 8'hFF, 1'b0);
    hold(8);
    step(cur ^ 8'h04, 8'hFF, 1'b0);
    hold(16);

    // clear coincident with an event
    step(cur ^ 8'h02, 8'hFF, 1'b0);
    step(cur ^ 8'h02, 8'hFF, 1'b1);
    hold(3);

    // reset mid-stretch then re-prime
    step(cur ^ 8'h40, 8'hFF, 1'b0);
    hold(3);
    pulse_reset();
    step(cur ^ 8'h08, 8'hFF, 1'b0);
    step(cur ^ 8'h08, 8'hFF, 1'b0);
    hold(12);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] tv;
      logic [7:0] mv;
      tv = ($urandom_range(0, 2) == 0) ? 8'($urandom) : cur;
      mv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(tv, mv, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
